// File: rtl/perf_fpga_req_sequencer.sv
// perf_fpga_req_sequencer: issues one host command to the perf engine once per repetition, times the batch and reports one status record
//   aclk/areset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready    host command handshake; cmd_type, cmd_n_beats, cmd_n_reps carry the command
//   eng_req_type/eng_n_beats/eng_busy/eng_done   engine request interface
//   stat_valid/stat_cycles/stat_reps/stat_error  one-cycle status record per command
//   idle                   sequencer is waiting for a command
module perf_fpga_req_sequencer #(
  parameter int TIMEOUT_CYCLES = 2**20,
  parameter int CNT_W = 64
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_type,
  input  logic [63:0]      cmd_n_beats,
  input  logic [31:0]      cmd_n_reps,
  output logic [1:0]       eng_req_type,
  output logic [63:0]      eng_n_beats,
  input  logic             eng_busy,
  input  logic             eng_done,
  output logic             stat_valid,
  output logic [CNT_W-1:0] stat_cycles,
  output logic [31:0]      stat_reps,
  output logic             stat_error,
  output logic             idle
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, REPORT} state_t;
  state_t state, state_nx;
  logic [1:0] type_reg;
  logic [31:0] n_reps_reg;
  logic [TW-1:0] rep_cyc;
  logic accept, in_rep, timeout, rep_done, last_rep, abort;
  assign accept   = cmd_valid && cmd_ready;
  assign in_rep   = state == ISSUE || state == RUN;
  // rep_cyc holds the cycles already spent in this rep, so this fires in the TIMEOUT_CYCLES-th cycle
  assign timeout  = rep_cyc == TW'(TIMEOUT_CYCLES - 1);
  assign rep_done = state == RUN && eng_done;
  assign last_rep = stat_reps + 32'd1 == n_reps_reg;
  // a completing done wins over a coinciding timeout
  assign abort    = in_rep && timeout && !rep_done;
  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx     = state;
    cmd_ready    = state == IDLE && !eng_busy;
    eng_req_type = state == ISSUE ? type_reg : 2'd0;
    stat_valid   = state == REPORT;
    idle         = state == IDLE;
    case (state)
      IDLE:    state_nx = !accept ? IDLE :
                          (cmd_type == 2'd0 || cmd_n_beats == '0 || cmd_n_reps == '0) ? REPORT : ISSUE;
      ISSUE:   state_nx = timeout ? REPORT : eng_busy ? RUN : ISSUE;
      RUN:     state_nx = rep_done ? (last_rep ? REPORT : ISSUE) : timeout ? REPORT : RUN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      type_reg    <= 2'd0;
      n_reps_reg  <= '0;
      eng_n_beats <= '0;
      stat_cycles <= '0;
      stat_reps   <= '0;
      stat_error  <= 1'b0;
      rep_cyc     <= '0;
    end else begin
      if (accept) begin
        type_reg    <= cmd_type;
        n_reps_reg  <= cmd_n_reps;
        eng_n_beats <= cmd_n_beats;
        stat_cycles <= '0;
        stat_reps   <= '0;
        stat_error  <= cmd_type == 2'd0;
      end
      if (in_rep && stat_cycles != '1) stat_cycles <= stat_cycles + CNT_W'(1);
      if (rep_done) stat_reps <= stat_reps + 32'd1;
      if (abort) stat_error <= 1'b1;
      rep_cyc <= (state_nx == ISSUE && state != ISSUE) ? '0 : in_rep ? rep_cyc + TW'(1) : rep_cyc;
    end
  end
endmodule
